// File: rtl/regs_wport_arbiter.sv
// regs_wport_arbiter: merges the in-order WB stream and long-latency results
// onto the single GPR write port, and tracks pending long-latency writes.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   wb_en, wb_reg, wb_data            pipeline writeback request
//   lu_issue, lu_issue_reg            long-latency issue (marks dest pending)
//   lu_issue_ready                    issue allowed (dest pending count < 3)
//   lu_valid, lu_reg, lu_data         long-latency result offer
//   lu_ready                          result queue can accept
//   rd_reg_a/b, hazard_a/b            decode sources and their hazard flags
//   RegWrite, wreg, wdata             registered register-file write port
module regs_wport_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_reg,
  output logic        lu_issue_ready,
  input  logic        lu_valid,
  input  logic [4:0]  lu_reg,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  rd_reg_a,
  input  logic [4:0]  rd_reg_b,
  output logic        hazard_a,
  output logic        hazard_b,
  output logic        RegWrite,
  output logic [4:0]  wreg,
  output logic [31:0] wdata
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREGS = 32;

  logic [4:0]       fifo_reg_q  [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]       pend_q [NREGS];
  logic [1:0]       pend_d [NREGS];
  logic [NREGS-1:0] inc_vec, dec_vec;

  logic        regwrite_q, regwrite_d;
  logic        src_fifo_q, src_fifo_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;

  logic full, empty, wb_grant, pop, push;
  logic [4:0]  head_reg;
  logic [31:0] head_data;

  // Queue status and arbitration decisions
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign wb_grant  = wb_en && (wb_reg != 5'd0);
  assign pop       = !wb_grant && !empty;
  assign push      = lu_valid && lu_ready;
  assign head_reg  = fifo_reg_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  assign lu_ready       = !full && !rst;
  assign lu_issue_ready = (pend_q[lu_issue_reg] != 2'd3);
  assign hazard_a       = (rd_reg_a != 5'd0) && (pend_q[rd_reg_a] != 2'd0);
  assign hazard_b       = (rd_reg_b != 5'd0) && (pend_q[rd_reg_b] != 2'd0);

  assign RegWrite = regwrite_q;
  assign wreg     = wreg_q;
  assign wdata    = wdata_q;

  // Write-port next state; a popped reg-0 entry burns its slot silently
  always_comb begin
    regwrite_d = 1'b0;
    src_fifo_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (wb_grant) begin
      regwrite_d = 1'b1;
      wreg_d     = wb_reg;
      wdata_d    = wb_data;
    end else if (pop && (head_reg != 5'd0)) begin
      regwrite_d = 1'b1;
      src_fifo_d = 1'b1;
      wreg_d     = head_reg;
      wdata_d    = head_data;
    end
  end

  // Queue pointers and occupancy
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    if (push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (push && !pop)      count_d = CNT_W'(count_q + 1'b1);
    else if (pop && !push) count_d = CNT_W'(count_q - 1'b1);
  end

  // Pending counters: retire is the edge at which a FIFO-sourced strobe commits
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (lu_issue && lu_issue_ready && (lu_issue_reg != 5'd0))
      inc_vec[lu_issue_reg] = 1'b1;
    if (regwrite_q && src_fifo_q && (pend_q[wreg_q] != 2'd0))
      dec_vec[wreg_q] = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      pend_d[i] = pend_q[i];
      if (inc_vec[i] && !dec_vec[i])      pend_d[i] = pend_q[i] + 2'd1;
      else if (dec_vec[i] && !inc_vec[i]) pend_d[i] = pend_q[i] - 2'd1;
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      src_fifo_q <= 1'b0;
      wreg_q     <= 5'd0;
      wdata_q    <= 32'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < NREGS; i++) pend_q[i] <= 2'd0;
    end else begin
      regwrite_q <= regwrite_d;
      src_fifo_q <= src_fifo_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < NREGS; i++) pend_q[i] <= pend_d[i];
    end
  end

  // Queue storage; contents are only meaningful under count_q
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= lu_reg;
      fifo_data_q[wr_ptr_q] <= lu_data;
    end
  end

endmodule

// File: tb/tb_regs_wport_arbiter.sv
// Directed table-driven bench for regs_wport_arbiter.
module tb_regs_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_reg;
  logic        lu_issue_ready;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  rd_reg_a, rd_reg_b;
  logic        hazard_a, hazard_b;
  logic        RegWrite;
  logic [4:0]  wreg;
  logic [31:0] wdata;

  regs_wport_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .lu_issue(lu_issue), .lu_issue_reg(lu_issue_reg), .lu_issue_ready(lu_issue_ready),
    .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data), .lu_ready(lu_ready),
    .rd_reg_a(rd_reg_a), .rd_reg_b(rd_reg_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .RegWrite(RegWrite), .wreg(wreg), .wdata(wdata)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; lur/irdy/ha/hb are checked before the edge,
  // rw/wr/wd are the write-port registers loaded by that edge.
  typedef struct {
    bit          rst;
    bit          wb;
    logic [4:0]  wr;
    logic [31:0] wd;
    bit          is;
    logic [4:0]  ir;
    bit          lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic [4:0]  ra;
    logic [4:0]  rb;
    bit          e_lur;
    bit          e_irdy;
    bit          e_ha;
    bit          e_hb;
    bit          e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t v(bit r, bit wb, logic [4:0] wr, logic [31:0] wd,
                             bit is, logic [4:0] ir, bit lv, logic [4:0] lr,
                             logic [31:0] ld, logic [4:0] ra, logic [4:0] rb,
                             bit elur, bit eirdy, bit eha, bit ehb,
                             bit erw, logic [4:0] ewr, logic [31:0] ewd);
    vec_t t;
    t.rst = r; t.wb = wb; t.wr = wr; t.wd = wd; t.is = is; t.ir = ir;
    t.lv = lv; t.lr = lr; t.ld = ld; t.ra = ra; t.rb = rb;
    t.e_lur = elur; t.e_irdy = eirdy; t.e_ha = eha; t.e_hb = ehb;
    t.e_rw = erw; t.e_wr = ewr; t.e_wd = ewd;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst = 1'b0; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    lu_issue = 1'b0; lu_issue_reg = '0; lu_valid = 1'b0; lu_reg = '0; lu_data = '0;
    rd_reg_a = '0; rd_reg_b = '0;
  endtask

  initial begin
    int waited;
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;

    //        rst wb wr  wd            is ir lv lr  ld            ra rb   lur ird ha hb  rw wr  wd
    // reset and idle
    vecs.push_back(v(1, 0, 0,  0,           0, 0, 0, 0,  0,           0, 0,   0, 1, 0, 0,  0, 0,  0));
    vecs.push_back(v(1, 0, 0,  0,           0, 0, 0, 0,  0,           0, 0,   0, 1, 0, 0,  0, 0,  0));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           0, 0,   1, 1, 0, 0,  0, 0,  0));
    // WB has priority over a queued result
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 1, 5,  32'hAAAA0005, 0, 0,  1, 1, 0, 0,  0, 0,  0));
    vecs.push_back(v(0, 1, 3,  32'h1234,    0, 0, 0, 0,  0,           0, 0,   1, 1, 0, 0,  1, 3,  32'h1234));
    vecs.push_back(v(0, 1, 3,  32'h1234,    0, 0, 0, 0,  0,           0, 0,   1, 1, 0, 0,  1, 3,  32'h1234));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           0, 0,   1, 1, 0, 0,  1, 5,  32'hAAAA0005));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           0, 0,   1, 1, 0, 0,  0, 5,  32'hAAAA0005));
    // scoreboard: two issues to r7, two results
    vecs.push_back(v(0, 0, 0,  0,           1, 7, 0, 0,  0,           7, 0,   1, 1, 0, 0,  0, 5,  32'hAAAA0005));
    vecs.push_back(v(0, 0, 0,  0,           1, 7, 0, 0,  0,           7, 0,   1, 1, 1, 0,  0, 5,  32'hAAAA0005));
    vecs.push_back(v(0, 0, 0,  0,           0, 7, 1, 7,  32'h11,      7, 0,   1, 1, 1, 0,  0, 5,  32'hAAAA0005));
    vecs.push_back(v(0, 0, 0,  0,           0, 7, 1, 7,  32'h22,      7, 0,   1, 1, 1, 0,  1, 7,  32'h11));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           7, 0,   1, 1, 1, 0,  1, 7,  32'h22));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           7, 7,   1, 1, 1, 1,  0, 7,  32'h22));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           7, 7,   1, 1, 0, 0,  0, 7,  32'h22));
    // saturation on r9, retire racing with issue
    vecs.push_back(v(0, 0, 0,  0,           1, 9, 0, 0,  0,           0, 9,   1, 1, 0, 0,  0, 7,  32'h22));
    vecs.push_back(v(0, 0, 0,  0,           1, 9, 0, 0,  0,           0, 9,   1, 1, 0, 1,  0, 7,  32'h22));
    vecs.push_back(v(0, 0, 0,  0,           1, 9, 0, 0,  0,           0, 9,   1, 1, 0, 1,  0, 7,  32'h22));
    vecs.push_back(v(0, 0, 0,  0,           1, 9, 1, 9,  32'h99,      0, 9,   1, 0, 0, 1,  0, 7,  32'h22));
    vecs.push_back(v(0, 0, 0,  0,           0, 9, 0, 0,  0,           0, 9,   1, 0, 0, 1,  1, 9,  32'h99));
    vecs.push_back(v(0, 0, 0,  0,           1, 9, 0, 0,  0,           0, 9,   1, 0, 0, 1,  0, 9,  32'h99));
    vecs.push_back(v(0, 0, 0,  0,           0, 9, 1, 9,  32'h98,      0, 9,   1, 1, 0, 1,  0, 9,  32'h99));
    vecs.push_back(v(0, 0, 0,  0,           0, 9, 0, 0,  0,           0, 9,   1, 1, 0, 1,  1, 9,  32'h98));
    vecs.push_back(v(0, 0, 0,  0,           1, 9, 0, 0,  0,           0, 9,   1, 1, 0, 1,  0, 9,  32'h98));
    vecs.push_back(v(0, 0, 0,  0,           0, 9, 0, 0,  0,           0, 9,   1, 1, 0, 1,  0, 9,  32'h98));
    vecs.push_back(v(0, 0, 0,  0,           1, 9, 0, 0,  0,           0, 9,   1, 1, 0, 1,  0, 9,  32'h98));
    vecs.push_back(v(0, 0, 0,  0,           0, 9, 0, 0,  0,           0, 9,   1, 0, 0, 1,  0, 9,  32'h98));
    // FIFO fills behind continuous WB, then drains in order
    vecs.push_back(v(0, 1, 10, 32'h1010,    0, 0, 1, 11, 32'hB1,      0, 0,   1, 1, 0, 0,  1, 10, 32'h1010));
    vecs.push_back(v(0, 1, 10, 32'h1010,    0, 0, 1, 12, 32'hB2,      0, 0,   1, 1, 0, 0,  1, 10, 32'h1010));
    vecs.push_back(v(0, 1, 10, 32'h1010,    0, 0, 1, 13, 32'hB3,      0, 0,   0, 1, 0, 0,  1, 10, 32'h1010));
    vecs.push_back(v(0, 1, 10, 32'h1010,    0, 0, 1, 13, 32'hB3,      0, 0,   0, 1, 0, 0,  1, 10, 32'h1010));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 1, 13, 32'hB3,      0, 0,   0, 1, 0, 0,  1, 11, 32'hB1));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 1, 13, 32'hB3,      0, 0,   1, 1, 0, 0,  1, 12, 32'hB2));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           0, 0,   1, 1, 0, 0,  1, 13, 32'hB3));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           0, 0,   1, 1, 0, 0,  0, 13, 32'hB3));
    // WB to r0 is idle, queued r4 wins; queued r0 is discarded
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 1, 4,  32'h44,      0, 0,   1, 1, 0, 0,  0, 13, 32'hB3));
    vecs.push_back(v(0, 1, 0,  32'hDEAD,    0, 0, 0, 0,  0,           0, 0,   1, 1, 0, 0,  1, 4,  32'h44));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 1, 0,  32'h77,      0, 0,   1, 1, 0, 0,  0, 4,  32'h44));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           0, 0,   1, 1, 0, 0,  0, 4,  32'h44));
    // reset with two queued entries and r4 pending
    vecs.push_back(v(0, 1, 20, 32'h2020,    1, 4, 0, 0,  0,           4, 0,   1, 1, 0, 0,  1, 20, 32'h2020));
    vecs.push_back(v(0, 1, 20, 32'h2020,    0, 0, 1, 4,  32'h401,     4, 0,   1, 1, 1, 0,  1, 20, 32'h2020));
    vecs.push_back(v(0, 1, 20, 32'h2020,    0, 0, 1, 6,  32'h601,     4, 0,   1, 1, 1, 0,  1, 20, 32'h2020));
    vecs.push_back(v(1, 0, 0,  0,           0, 0, 0, 0,  0,           4, 4,   0, 1, 1, 1,  0, 0,  0));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           4, 4,   1, 1, 0, 0,  0, 0,  0));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           4, 4,   1, 1, 0, 0,  0, 0,  0));
    vecs.push_back(v(0, 0, 0,  0,           0, 0, 0, 0,  0,           4, 4,   1, 1, 0, 0,  0, 0,  0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; wb_en = vecs[i].wb; wb_reg = vecs[i].wr; wb_data = vecs[i].wd;
      lu_issue = vecs[i].is; lu_issue_reg = vecs[i].ir;
      lu_valid = vecs[i].lv; lu_reg = vecs[i].lr; lu_data = vecs[i].ld;
      rd_reg_a = vecs[i].ra; rd_reg_b = vecs[i].rb;
      #1;
      chk("lu_ready", i, 32'(lu_ready), 32'(vecs[i].e_lur));
      chk("lu_issue_ready", i, 32'(lu_issue_ready), 32'(vecs[i].e_irdy));
      chk("hazard_a", i, 32'(hazard_a), 32'(vecs[i].e_ha));
      chk("hazard_b", i, 32'(hazard_b), 32'(vecs[i].e_hb));
      @(posedge clk); #1;
      chk("RegWrite", i, 32'(RegWrite), 32'(vecs[i].e_rw));
      chk("wreg", i, 32'(wreg), 32'(vecs[i].e_wr));
      chk("wdata", i, wdata, vecs[i].e_wd);
    end

    // LU latency: accepted in cycle N, strobe observed in cycle N+2
    drive_idle();
    lu_valid = 1'b1; lu_reg = 5'd15; lu_data = 32'h1515;
    @(posedge clk); #1;
    drive_idle();
    waited = 1;
    while (!RegWrite && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("lu_latency", 100, 32'(waited), 32'd2);
    chk("lu_lat_wreg", 100, 32'(wreg), 32'd15);
    chk("lu_lat_wdata", 100, wdata, 32'h1515);
    @(posedge clk); #1;
    chk("lu_lat_done", 101, 32'(RegWrite), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
